// File: rtl/wired_cdb_arbiter_pkg.sv
// Shared types and constants for the CDB arbiter: the CDB entry record,
// lane count and producer index constants.
package wired_cdb_arbiter_pkg;

  localparam int CDB_LANE_CNT = 2;
  localparam int CDB_AGE_W    = 4;

  localparam int CDB_SRC_ALU0 = 0;
  localparam int CDB_SRC_ALU1 = 1;
  localparam int CDB_SRC_LSU  = 2;
  localparam int CDB_SRC_MDU  = 3;
  localparam int CDB_SRC_FPU  = 4;

  typedef struct packed {
    logic        valid;
    logic [7:0]  wid;
    logic [31:0] wdata;
  } pipeline_cdb_t;

  function automatic logic cdb_bank(input pipeline_cdb_t e);
    return e.wid[0];
  endfunction

endpackage

// File: rtl/wired_cdb_lane_sel.sv
// Per-lane fixed-priority picker with payload mux; lowest index wins.
// With WIRED_CDB_AGING_EN defined, aged requesters outrank all others.
module wired_cdb_lane_sel
  import wired_cdb_arbiter_pkg::*;
#(
  parameter int SRC_CNT = 5
) (
  input  logic [SRC_CNT-1:0]          req_i,
`ifdef WIRED_CDB_AGING_EN
  input  logic [SRC_CNT-1:0]          aged_i,
`endif
  input  pipeline_cdb_t [SRC_CNT-1:0] src_cdb_i,
  output logic [SRC_CNT-1:0]          gnt_o,
  output pipeline_cdb_t               lane_cdb_o
);

  logic [SRC_CNT-1:0] cand;

  always_comb begin
`ifdef WIRED_CDB_AGING_EN
    cand = (|(req_i & aged_i)) ? (req_i & aged_i) : req_i;
`else
    cand = req_i;
`endif
    gnt_o      = '0;
    lane_cdb_o = '0;
    // Walk from the lowest priority upward so the lowest index overwrites last.
    for (int i = SRC_CNT - 1; i >= 0; i--) begin
      if (cand[i]) begin
        gnt_o      = '0;
        gnt_o[i]   = 1'b1;
        lane_cdb_o = src_cdb_i[i];
      end
    end
  end

endmodule

// File: rtl/wired_cdb_arbiter.sv
// Two-lane CDB arbiter: lane k takes only entries whose wid[0]==k.
// Optional wait-counter aging is enabled by defining WIRED_CDB_AGING_EN.
module wired_cdb_arbiter
  import wired_cdb_arbiter_pkg::*;
#(
  parameter int SRC_CNT   = 5,
  parameter int AGE_LIMIT = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  pipeline_cdb_t [SRC_CNT-1:0]      src_cdb_i,
  output logic [SRC_CNT-1:0]               src_ready_o,
  output pipeline_cdb_t [CDB_LANE_CNT-1:0] cdb_o,
  input  logic                             flush_i
);

  logic [CDB_LANE_CNT-1:0][SRC_CNT-1:0] req;
  logic [CDB_LANE_CNT-1:0][SRC_CNT-1:0] gnt;
  pipeline_cdb_t [CDB_LANE_CNT-1:0]     lane_cdb;
  pipeline_cdb_t [CDB_LANE_CNT-1:0]     cdb_d;
  pipeline_cdb_t [CDB_LANE_CNT-1:0]     cdb_q;

`ifdef WIRED_CDB_AGING_EN
  localparam logic [CDB_AGE_W-1:0] AGE_LIM_V = CDB_AGE_W'(AGE_LIMIT);
  localparam logic [CDB_AGE_W-1:0] AGE_MAX_V = '1;

  logic [SRC_CNT-1:0][CDB_AGE_W-1:0] age_d;
  logic [SRC_CNT-1:0][CDB_AGE_W-1:0] age_q;
  logic [SRC_CNT-1:0]                aged;
`endif

  always_comb begin
    req = '0;
    for (int i = 0; i < SRC_CNT; i++) begin
      for (int k = 0; k < CDB_LANE_CNT; k++) begin
        if (!rst && !flush_i && src_cdb_i[i].valid &&
            (cdb_bank(src_cdb_i[i]) == 1'(k))) begin
          req[k][i] = 1'b1;
        end
      end
    end
  end

  for (genvar k = 0; k < CDB_LANE_CNT; k++) begin : g_lane
    wired_cdb_lane_sel #(
      .SRC_CNT (SRC_CNT)
    ) u_lane_sel (
      .req_i      (req[k]),
`ifdef WIRED_CDB_AGING_EN
      .aged_i     (aged),
`endif
      .src_cdb_i  (src_cdb_i),
      .gnt_o      (gnt[k]),
      .lane_cdb_o (lane_cdb[k])
    );
  end

  always_comb begin
    src_ready_o = '0;
    cdb_d       = '0;
    for (int k = 0; k < CDB_LANE_CNT; k++) begin
      src_ready_o     = src_ready_o | gnt[k];
      cdb_d[k]        = lane_cdb[k];
      cdb_d[k].valid  = |gnt[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cdb_q <= '0;
    end else begin
      cdb_q <= cdb_d;
    end
  end

  // An entry registered the cycle before a flush is suppressed on the way out.
  always_comb begin
    cdb_o = cdb_q;
    for (int k = 0; k < CDB_LANE_CNT; k++) begin
      cdb_o[k].valid = cdb_q[k].valid & ~flush_i;
    end
  end

`ifdef WIRED_CDB_AGING_EN
  always_comb begin
    aged  = '0;
    age_d = age_q;
    for (int i = 0; i < SRC_CNT; i++) begin
      aged[i] = (age_q[i] >= AGE_LIM_V);
      if (flush_i || !src_cdb_i[i].valid || src_ready_o[i]) begin
        age_d[i] = '0;
      end else if (age_q[i] != AGE_MAX_V) begin
        age_d[i] = age_q[i] + CDB_AGE_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      age_q <= '0;
    end else begin
      age_q <= age_d;
    end
  end
`endif

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!rst) begin
      assert (AGE_LIMIT > 0 && AGE_LIMIT <= 15)
        else $error("cdb arbiter: AGE_LIMIT out of range");
      assert ($countones(src_ready_o) <= 2)
        else $error("cdb arbiter: more than two grants");
      for (int k = 0; k < CDB_LANE_CNT; k++) begin
        for (int i = 0; i < SRC_CNT; i++) begin
          assert (!gnt[k][i] ||
                  (src_cdb_i[i].valid && cdb_bank(src_cdb_i[i]) == 1'(k)))
            else $error("cdb arbiter: grant to src %0d on lane %0d invalid", i, k);
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_wired_cdb_arbiter.sv
// Directed bench for wired_cdb_arbiter; expectations track WIRED_CDB_AGING_EN.
module tb_wired_cdb_arbiter;
  import wired_cdb_arbiter_pkg::*;

  logic                 clk;
  logic                 rst;
  logic                 flush;
  pipeline_cdb_t [4:0]  src;
  logic [4:0]           rdy;
  pipeline_cdb_t [1:0]  cdb;

  int n_assert = 0;
  int n_fail   = 0;

`ifdef WIRED_CDB_AGING_EN
  localparam int AGE_THR = 8;
`else
  localparam int AGE_THR = 16;
`endif

  wired_cdb_arbiter #(
    .SRC_CNT   (5),
    .AGE_LIMIT (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .src_cdb_i   (src),
    .src_ready_o (rdy),
    .cdb_o       (cdb),
    .flush_i     (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic pipeline_cdb_t mk(input logic [7:0] w, input logic [31:0] d);
    pipeline_cdb_t e;
    e.valid = 1'b1;
    e.wid   = w;
    e.wdata = d;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int         cnt4;
  logic [4:0] exp_r;
  logic [7:0] exp_wid;

  initial begin
    rst   = 1'b1;
    flush = 1'b0;
    src   = '0;
    tick();
    tick();
    chk("rst_ready", 32'(rdy), 32'h0);
    chk("rst_lane0_valid", 32'(cdb[0].valid), 32'h0);
    chk("rst_lane1_valid", 32'(cdb[1].valid), 32'h0);
    chk("rst_lane1_wdata", cdb[1].wdata, 32'h0);
    rst = 1'b0;

    // single request from FPU, bank 1
    src[4] = mk(8'h07, 32'h3F80_0000);
    #1 chk("single_ready", 32'(rdy), 32'h10);
    tick();
    src = '0;
    chk("single_l1_valid", 32'(cdb[1].valid), 32'h1);
    chk("single_l1_wid", 32'(cdb[1].wid), 32'h07);
    chk("single_l1_wdata", cdb[1].wdata, 32'h3F80_0000);
    chk("single_l0_valid", 32'(cdb[0].valid), 32'h0);

    // one request per bank
    src[0] = mk(8'h02, 32'hAAAA_0002);
    src[2] = mk(8'h05, 32'hBBBB_0005);
    #1 chk("dual_ready", 32'(rdy), 32'h05);
    tick();
    src = '0;
    chk("dual_l0_valid", 32'(cdb[0].valid), 32'h1);
    chk("dual_l0_wid", 32'(cdb[0].wid), 32'h02);
    chk("dual_l0_wdata", cdb[0].wdata, 32'hAAAA_0002);
    chk("dual_l1_valid", 32'(cdb[1].valid), 32'h1);
    chk("dual_l1_wid", 32'(cdb[1].wid), 32'h05);
    chk("dual_l1_wdata", cdb[1].wdata, 32'hBBBB_0005);

    // bank conflict: src1 beats src3, src3 holds and goes next
    src[1] = mk(8'h04, 32'hC1C1_0004);
    src[3] = mk(8'h06, 32'hC3C3_0006);
    #1 chk("conf_ready_a", 32'(rdy), 32'h02);
    tick();
    src[1] = '0;
    chk("conf_l0_wid_a", 32'(cdb[0].wid), 32'h04);
    chk("conf_l0_valid_a", 32'(cdb[0].valid), 32'h1);
    #1 chk("conf_ready_b", 32'(rdy), 32'h08);
    tick();
    src = '0;
    chk("conf_l0_wid_b", 32'(cdb[0].wid), 32'h06);
    chk("conf_l0_wdata_b", cdb[0].wdata, 32'hC3C3_0006);
    chk("conf_l1_valid_b", 32'(cdb[1].valid), 32'h0);
    tick();
    chk("idle_l0_valid", 32'(cdb[0].valid), 32'h0);

    // flush right after a grant drops that entry
    src[0] = mk(8'h02, 32'hD0D0_0002);
    #1 chk("flush_grant_ready", 32'(rdy), 32'h01);
    tick();
    src[0] = '0;
    src[2] = mk(8'h08, 32'hE2E2_0008);
    flush  = 1'b1;
    #1;
    chk("flush_n1_l0_valid", 32'(cdb[0].valid), 32'h0);
    chk("flush_n1_ready", 32'(rdy), 32'h0);
    tick();
    chk("flush_n2_l0_valid", 32'(cdb[0].valid), 32'h0);
    chk("flush_n2_l1_valid", 32'(cdb[1].valid), 32'h0);
    chk("flush_n2_ready", 32'(rdy), 32'h0);
    flush = 1'b0;
    #1 chk("post_flush_ready", 32'(rdy), 32'h04);
    tick();
    src = '0;
    chk("post_flush_l0_valid", 32'(cdb[0].valid), 32'h1);
    chk("post_flush_l0_wid", 32'(cdb[0].wid), 32'h08);

    // reset for one cycle with every source valid
    src[0] = mk(8'h10, 32'h0000_0010);
    src[1] = mk(8'h11, 32'h0000_0011);
    src[2] = mk(8'h12, 32'h0000_0012);
    src[3] = mk(8'h13, 32'h0000_0013);
    src[4] = mk(8'h14, 32'h0000_0014);
    rst = 1'b1;
    #1 chk("midrst_ready", 32'(rdy), 32'h0);
    tick();
    chk("midrst_l0_valid", 32'(cdb[0].valid), 32'h0);
    chk("midrst_l1_valid", 32'(cdb[1].valid), 32'h0);
    chk("midrst_l0_wid", 32'(cdb[0].wid), 32'h0);
    rst = 1'b0;
    #1 chk("resume_ready", 32'(rdy), 32'h03);
    tick();
    src = '0;
    chk("resume_l0_wid", 32'(cdb[0].wid), 32'h10);
    chk("resume_l1_wid", 32'(cdb[1].wid), 32'h11);
    chk("resume_l1_valid", 32'(cdb[1].valid), 32'h1);
    tick();

    // src0 and src4 both keep requesting bank 0
    src[0] = mk(8'h20, 32'h0000_0A20);
    src[4] = mk(8'h22, 32'h0000_0A22);
    cnt4 = 0;
    for (int c = 1; c <= 12; c++) begin
      exp_r   = (cnt4 >= AGE_THR) ? 5'b10000 : 5'b00001;
      exp_wid = exp_r[4] ? 8'h22 : 8'h20;
      #1 chk("age_ready", 32'(rdy), 32'(exp_r));
      cnt4 = exp_r[4] ? 0 : ((cnt4 < 15) ? cnt4 + 1 : 15);
      tick();
      chk("age_l0_wid", 32'(cdb[0].wid), 32'(exp_wid));
    end
    src = '0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/wired_cdb_arbiter.md
Name: wired_cdb_arbiter

Overview:
- Sits downstream of every issue-queue commit FIFO: ALU0, ALU1, LSU, MDU and FPU.
- Each cycle it grants at most two `pipeline_cdb_t` entries onto the two CDB lanes.
- Lane k writes only ROB bank k, where bank = `wid[0]`, so a bank conflict can never occur.
- Grants use fixed priority (lower index wins). Outputs are registered and feed both the ROB and every issue queue's CDB snoop port.

Parameters:
- `SRC_CNT`, 5, number of producer ports; index 0 has the highest priority (ALU0, ALU1, LSU, MDU, FPU).
- `AGE_LIMIT`, 8, cycles a valid source may wait before it is promoted. Used only with `WIRED_CDB_AGING_EN`.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `src_cdb_i`  in  `SRC_CNT` x `pipeline_cdb_t`  producer entries; `.valid` marks a request.
- `src_ready_o`  out  `SRC_CNT`  grant; the producer pops its FIFO when valid & ready.
- `cdb_o`  out  2 x `pipeline_cdb_t`  registered CDB lanes; lane k carries `wid[0]==k` only.
- `flush_i`  in  1  backend flush.

Behaviour:
- **Reset:** on `rst` at the clock edge, `cdb_o[k].valid=0` and all other `cdb_o` fields are 0. `src_ready_o` is combinational and is 0 while `rst` or `flush_i` is high.
- **Request partition:** source i requests lane k when `src_cdb_i[i].valid && src_cdb_i[i].wid[0]==k`.
- **Grant:** per lane, the lowest-index requester wins; `src_ready_o[i]=1` only for winners.
  - At most one grant per lane; at most two grants per cycle.
  - A source never holds two grants, because it requests only one lane.
- **Latency:** a granted entry appears on `cdb_o[k]` exactly one cycle after the grant. All payload fields are copied unchanged.
- **Idle lane:** a lane with no requester registers `valid=0`. Its payload may hold stale values; consumers ignore payload when `valid=0`.
- **No backpressure:** the CDB is broadcast, so the output register loads every cycle.
- **Simultaneous requests:** if two sources target the same bank, the lower index wins. The loser keeps `valid` asserted, gets no ready, and must hold its payload stable.
- **Flush:**
  - While `flush_i=1`, no grants are issued.
  - At the edge where `flush_i=1`, `cdb_o` valid bits clear. An entry granted in the cycle before the flush is therefore dropped.
  - Age counters clear under flush, as they do under reset.
- **Reset mid-operation:** identical to flush, and also clears all registers.
- **Assertions (sim only):** `popcount(src_ready_o)<=2`. A granted source must have `valid=1` and the matching bank bit.

Optional Feature:
- **Macro:** `WIRED_CDB_AGING_EN`.
- **Defined:**
  - Each source has a 4-bit wait counter.
  - The counter increments each cycle the source is valid and not granted, and saturates at 15.
  - It clears on grant, on `valid=0`, on flush, and on reset.
  - A source whose counter is >= `AGE_LIMIT` outranks all non-aged requesters on its lane.
  - Among aged requesters on the same lane, the lower index still wins.
- **Undefined:** pure fixed priority; the counters and aging logic are not present.

Decomposition:
- **Package `wired0_defines.svh`:** reuse `pipeline_cdb_t`.
- **New constants in the package:** `CDB_LANE_CNT=2` and `CDB_SRC_ALU0..CDB_SRC_FPU` index constants.
- **Sub-module `wired_cdb_lane_sel`:**
  - One instance per lane.
  - Inputs: request vector, plus the aged vector when aging is enabled.
  - Outputs: one-hot grant and payload mux.
  - The top level handles request partitioning, the output register, the flush/reset logic and the aging counters.

Test Plan:
- **Single request:** src 4 (FPU) valid, wid=0x07, wdata=0x3F800000 -> `src_ready_o=5'b10000` that cycle. Next cycle `cdb_o[1].valid=1` with wid=0x07, wdata=0x3F800000; `cdb_o[0].valid=0`.
- **Dual lane:** src0 wid=0x02 and src2 wid=0x05 together -> both granted, `src_ready_o=5'b00101`. Next cycle lane0 wid=0x02 and lane1 wid=0x05.
- **Bank conflict:** src1 wid=0x04 and src3 wid=0x06 (both bank 0) -> src1 granted; src3 waits with payload held and is granted the following cycle. `cdb_o[0]` shows 0x04, then 0x06, on consecutive cycles.
- **Flush drop:** grant src0 at cycle N, assert `flush_i` at N+1 -> `cdb_o[0].valid=0` at N+1 and N+2. `src_ready_o=0` while flush is high.
- **Reset:** assert `rst` for 1 cycle with all sources valid -> no ready, all `cdb_o` valid bits 0. Normal grants resume the cycle after `rst` falls.
- **Aging (`WIRED_CDB_AGING_EN`):** src0 and src4 continuously request bank 0 -> src4 is granted no later than cycle 9 (`AGE_LIMIT` reached), then src0 resumes. Without the macro, src4 is never granted while src0 stays valid.
